// File: rtl/usb_rx_pkg.sv
// USB receive path shared types and constants.
// Used by the bit-timing stage and its counters.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA
  } timerState;

  localparam int USB_CLKS_PER_BIT  = 8;
  localparam int USB_STUFF_LEN     = 6;
  localparam int USB_BITS_PER_BYTE = 8;

endpackage

// File: rtl/flex_counter.sv
// Rollover counter with load, clear and enable.
// Load beats clear, clear beats enable; wraps after rollover_val_i.
module flex_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         count_enable_i,
  input  logic [W-1:0] rollover_val_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (clear_i) begin
      count_d = '0;
    end else if (count_enable_i) begin
      if (count_q == rollover_val_i) begin
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/rx_timer.sv
// USB receive bit timing, byte framing and bit unstuffing.
// Resyncs on each data edge; drops stuffed bits after the sync byte.
module rx_timer
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT  = USB_CLKS_PER_BIT,
  parameter int SAMPLE_OFFSET = 3,
  parameter int BITS_PER_BYTE = USB_BITS_PER_BYTE,
  parameter int STUFF_LEN     = USB_STUFF_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_edge,
  input  logic       rcving,
  input  logic       d_orig,
  output logic       shift_enable,
  output logic       byte_received,
  output logic       stuff_error,
  output logic [2:0] bit_cnt
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(BITS_PER_BYTE);
  localparam int OW = $clog2(STUFF_LEN + 1);

  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CLK_SMP  = CW'(SAMPLE_OFFSET);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_BYTE - 1);
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);

  timerState     state_q;
  logic [OW-1:0] ones_cnt_q;
  logic [OW-1:0] ones_cnt_d;
  logic          byte_q;
  logic [CW-1:0] clk_cnt;
  logic [BW-1:0] bit_cnt_w;
  logic          sample;
  logic          stuffed;
  logic          byte_done;

  // A coincident edge wins: resync, no sample this cycle.
  assign sample = rcving & (clk_cnt == CLK_SMP) & ~d_edge;

  assign stuffed = sample & (state_q == DATA)
                 & (ones_cnt_q == ONES_MAX);

  assign shift_enable = sample & (state_q != IDLE) & ~stuffed;
  assign stuff_error  = stuffed & d_orig;
  assign byte_done    = shift_enable & (bit_cnt_w == BIT_LAST);

  flex_counter #(.W(CW)) u_clk_cnt (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (~rcving),
    .load_i        (d_edge),
    .load_val_i    (CW'(1)),
    .count_enable_i(rcving),
    .rollover_val_i(CLK_LAST),
    .count_o       (clk_cnt)
  );

  flex_counter #(.W(BW)) u_bit_cnt (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (~rcving),
    .load_i        (1'b0),
    .load_val_i    ('0),
    .count_enable_i(shift_enable),
    .rollover_val_i(BIT_LAST),
    .count_o       (bit_cnt_w)
  );

  always_comb begin
    ones_cnt_d = ones_cnt_q;
    if (!rcving || state_q != DATA) begin
      ones_cnt_d = '0;
    end else if (stuffed) begin
      ones_cnt_d = '0;
    end else if (shift_enable) begin
      if (!d_orig) begin
        ones_cnt_d = '0;
      end else if (ones_cnt_q != ONES_MAX) begin
        ones_cnt_d = ones_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ones_cnt_q <= '0;
      byte_q     <= 1'b0;
    end else begin
      ones_cnt_q <= ones_cnt_d;
      byte_q     <= byte_done;
      if (!rcving) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE:    state_q <= SYNC;
          SYNC:    if (byte_done) state_q <= DATA;
          DATA:    state_q <= DATA;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign byte_received = byte_q;
  assign bit_cnt       = 3'(bit_cnt_w);

endmodule

// File: tb/tb_rx_timer.sv
// Directed bench for rx_timer: timing, resync, unstuffing, reset.
// Strobes are logged per cycle and compared to hand-derived cycles.
module tb_rx_timer;
  import usb_rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_edge = 1'b0;
  logic       rcving = 1'b0;
  logic       d_orig = 1'b0;
  logic       shift_enable;
  logic       byte_received;
  logic       stuff_error;
  logic [2:0] bit_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int k;
  int se_n, br_n, er_n;
  int se_first, se_last, br_last, er_last;

  always #5 clk = ~clk;

  rx_timer u_dut (
    .clk          (clk),
    .rst          (rst),
    .d_edge       (d_edge),
    .rcving       (rcving),
    .d_orig       (d_orig),
    .shift_enable (shift_enable),
    .byte_received(byte_received),
    .stuff_error  (stuff_error),
    .bit_cnt      (bit_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    se_n = 0; br_n = 0; er_n = 0;
    se_first = -1; se_last = -1;
    br_last = -1; er_last = -1;
  endtask

  // Drive one cycle, log strobes, advance to next cycle.
  task automatic cyc(input logic e, input logic r, input logic d);
    d_edge = e; rcving = r; d_orig = d;
    #1;
    if (shift_enable === 1'b1) begin
      se_n++;
      if (se_first < 0) se_first = k;
      se_last = k;
    end
    if (byte_received === 1'b1) begin
      br_n++; br_last = k;
    end
    if (stuff_error === 1'b1) begin
      er_n++; er_last = k;
    end
    @(posedge clk); #1;
    k++;
  endtask

  initial begin
    #3;
    check("rst_se", shift_enable, 0);
    check("rst_br", byte_received, 0);
    check("rst_er", stuff_error, 0);
    check("rst_bc", bit_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Free-running sync byte then resync in DATA
    k = 0; clr();
    cyc(1'b1, 1'b0, 1'b0);
    while (k < 62) cyc(1'b0, 1'b1, 1'b0);
    check("a_se_n", se_n, 8);
    check("a_se_first", se_first, 3);
    check("a_se_last", se_last, 59);
    check("a_br_n", br_n, 1);
    check("a_br_at", br_last, 60);
    check("a_bc", bit_cnt, 0);
    check("a_st", u_dut.state_q, DATA);
    clr();
    cyc(1'b1, 1'b1, 1'b0);
    while (k < 67) cyc(1'b0, 1'b1, 1'b0);
    check("b_se_n", se_n, 1);
    check("b_se_at", se_last, 65);
    check("b_bc", bit_cnt, 1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    check("b_idle_bc", bit_cnt, 0);
    check("b_idle_st", u_dut.state_q, IDLE);

    // Ones in sync, six 1s then a stuffed 0
    k = 0; clr();
    cyc(1'b1, 1'b0, 1'b1);
    while (k < 61) cyc(1'b0, 1'b1, 1'b1);
    check("c_sync_se", se_n, 8);
    check("c_sync_br", br_n, 1);
    check("c_sync_er", er_n, 0);
    clr();
    while (k < 112) cyc(1'b0, 1'b1, 1'b1);
    while (k < 117) cyc(1'b0, 1'b1, 1'b0);
    check("c_se_n", se_n, 6);
    check("c_se_last", se_last, 107);
    check("c_er_n", er_n, 0);
    check("c_bc", bit_cnt, 6);
    check("c_ones", u_dut.ones_cnt_q, 0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    // Stuffed position carries a 1
    k = 0; clr();
    cyc(1'b1, 1'b0, 1'b1);
    while (k < 61) cyc(1'b0, 1'b1, 1'b1);
    clr();
    while (k < 118) cyc(1'b0, 1'b1, 1'b1);
    check("d_er_n", er_n, 1);
    check("d_er_at", er_last, 115);
    check("d_se_n", se_n, 6);
    check("d_se_last", se_last, 107);
    check("d_bc", bit_cnt, 6);
    check("d_ones", u_dut.ones_cnt_q, 0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    // Reset mid-byte
    k = 0; clr();
    cyc(1'b1, 1'b0, 1'b0);
    while (k < 37) cyc(1'b0, 1'b1, 1'b0);
    check("f_pre_bc", bit_cnt, 5);
    rst = 1'b1;
    #1;
    check("f_rst_se", shift_enable, 0);
    check("f_rst_br", byte_received, 0);
    check("f_rst_er", stuff_error, 0);
    check("f_rst_bc", bit_cnt, 0);
    clr();
    repeat (10) cyc(k % 4 == 0, 1'b1, 1'b1);
    check("f_hold_se", se_n, 0);
    check("f_hold_br", br_n, 0);
    rst = 1'b0;
    clr();
    repeat (20) cyc(1'b0, 1'b0, 1'b1);
    check("f_post_se", se_n, 0);
    check("f_post_br", br_n, 0);
    check("f_post_er", er_n, 0);
    check("f_post_st", u_dut.state_q, IDLE);
    check("f_post_bc", bit_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_timer.md
Name: rx_timer

Overview:
- Bit-timing and byte-framing stage of the USB receive path; sits directly upstream of the receiver control unit.
- Generates the `shift_enable` and `byte_received` strobes that the control unit and the receive shift register consume.
- Tracks 8x-oversampled bit periods and resynchronises on every decoded data edge.
- After the sync byte, performs bit-unstuffing: suppresses the shift for a stuffed bit and flags stuffing violations.

Parameters:
- CLKS_PER_BIT, 8, system clocks per USB bit period.
- SAMPLE_OFFSET, 3, clock count within the bit period at which the bit is sampled (0 < SAMPLE_OFFSET < CLKS_PER_BIT).
- BITS_PER_BYTE, 8, accepted bits per byte_received pulse.
- STUFF_LEN, 6, consecutive decoded 1s after which the next bit is a stuffed bit.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- d_edge  in  1  one-cycle pulse on a line transition (from the edge detector).
- rcving  in  1  packet-in-progress level from the receiver control unit.
- d_orig  in  1  NRZI-decoded bit; valid at the sample point.
- shift_enable  out  1  one-cycle strobe: shift d_orig into the receive shift register.
- byte_received  out  1  one-cycle strobe: BITS_PER_BYTE bits have been shifted.
- stuff_error  out  1  one-cycle strobe: the stuffed-bit position carried a 1.
- bit_cnt  out  3  accepted bits in the current byte, 0..7.

Behaviour:
- Reset (async, rst=1): clk_cnt=0, bit_cnt=0, ones_cnt=0, state=IDLE; shift_enable, byte_received and stuff_error are all 0.
- Clock counter (clk_cnt, width $clog2(CLKS_PER_BIT)):
  - d_edge=1 loads clk_cnt<=1, regardless of rcving. The edge cycle counts as position 0.
  - Otherwise, with rcving=1: clk_cnt increments and wraps from CLKS_PER_BIT-1 to 0.
  - Otherwise, with rcving=0: clk_cnt<=0.
- Sample point: sample = rcving & (clk_cnt==SAMPLE_OFFSET) & ~d_edge. If d_edge coincides with the sample count, the resync wins and there is no sample that cycle.
- State machine (states IDLE, SYNC, DATA):
  - IDLE: on rcving=1, go to SYNC. Counters are held at 0.
  - SYNC: every sample is accepted (no stuff check). When the byte_received pulse for byte 0 is issued, go to DATA.
  - DATA: stuff checking is active.
  - Any state: rcving=0 returns to IDLE next cycle and clears bit_cnt and ones_cnt synchronously.
- Stuffing, in DATA only:
  - A sample with ones_cnt==STUFF_LEN is a stuffed bit. shift_enable stays 0 and ones_cnt<=0.
  - If d_orig==1 at that stuffed-bit sample, stuff_error=1 for that cycle.
  - On an accepted sample: ones_cnt<=ones_cnt+1 if d_orig=1 (saturating at STUFF_LEN), else 0.
  - In SYNC, ones_cnt is held at 0.
- shift_enable is combinational and asserted in the sample cycle for every accepted (non-stuffed) bit.
- Bit counter: bit_cnt increments on each shift_enable. At BITS_PER_BYTE-1 it wraps to 0.
- byte_received is registered: high exactly one cycle after the shift_enable that completed the byte, so rcv_data is already updated when the control unit sees it.
- The byte_received pulse is still issued if rcving falls in the same cycle as the completing shift_enable.
- Latency: shift_enable fires SAMPLE_OFFSET clocks after the resync edge; byte_received fires 1 clock after the 8th shift_enable.
- A stuffed bit does not advance bit_cnt, so a byte containing a stuffed bit spans 9 bit periods.
- Without edges (long runs), clk_cnt free-runs, producing one sample every CLKS_PER_BIT clocks.
- Reset mid-packet: immediate return to the reset values above; no strobe is generated during reset.

Decomposition:
- Shared package usb_rx_pkg:
  - typedef timerState {IDLE, SYNC, DATA}.
  - Constants USB_CLKS_PER_BIT=8, USB_STUFF_LEN=6, USB_BITS_PER_BYTE=8.
- One natural sub-module: flex_counter (parameterised rollover counter with clear and enable). Instantiate it twice, for clk_cnt and bit_cnt. The ones_cnt and stuffing logic stays inline.

Test Plan:
- Idle, then a d_edge at cycle t with rcving rising at t+1 and no further edges: shift_enable at t+3, t+11, …; byte_received at t+60 (one cycle after the 8th shift_enable at t+59); bit_cnt back to 0.
- Resync: an edge at clk_cnt=6 reloads the counter to 1. The next shift_enable comes exactly 3 cycles after that edge, with no extra sample.
- After the sync byte, data bits 1,1,1,1,1,1 then d_orig=0: six shift_enables, no shift on the 7th bit period, ones_cnt=0, bit_cnt=6, stuff_error=0.
- Same as above but d_orig=1 at the stuffed bit: stuff_error pulses for exactly 1 cycle at that sample; there is no shift_enable.
- Seven decoded 1s during the sync byte: all 8 sync bits are shifted, with no stuffing and no stuff_error.
- rst asserted at bit_cnt=5 mid-byte: all outputs are 0 immediately. After release with rcving=0, state=IDLE and there are no strobes.
